// File: rtl/ps2_pkg.sv
// PS/2 system-bus keyboard controller: shared types and register map.
// Receive FSM states, register byte offsets and status bit positions.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic [23:0] OFS_CODE   = 24'h00;
   localparam logic [23:0] OFS_UNREAD = 24'h04;
   localparam logic [23:0] OFS_STATUS = 24'h08;
   localparam logic [23:0] OFS_RST    = 24'h24;

   localparam int ST_PAR = 0;
   localparam int ST_FRM = 1;
   localparam int ST_OVR = 2;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, kclk fall detect,
// deframing FSM and inter-edge timeout. Result outputs are 1-cycle pulses.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       kclk_i,
   input  logic       kdata_i,
   output logic [7:0] code_o,
   output logic       code_vld_o,
   output logic       par_err_o,
   output logic       frm_err_o
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]  kclk_sync;
   logic [1:0]  kdat_sync;
   logic        fall;
   logic        bit_in;

   rx_state_t   state, state_n;
   logic [2:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  shreg, shreg_n;
   logic        par_ok, par_ok_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n;

   // two-flop synchronizers plus one history flop on kclk for edge detect
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         kclk_sync <= 3'b111;
         kdat_sync <= 2'b11;
      end else begin
         kclk_sync <= {kclk_sync[1:0], kclk_i};
         kdat_sync <= {kdat_sync[0], kdata_i};
      end
   end

   assign fall   = kclk_sync[2] & ~kclk_sync[1];
   assign bit_in = kdat_sync[1];
   assign code_o = shreg;

   // receive state and datapath registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_ok  <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         par_ok  <= par_ok_n;
         tmo_cnt <= tmo_cnt_n;
      end
   end

   // next-state: one step per kclk fall, timeout abandons a partial frame
   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      par_ok_n   = par_ok;
      tmo_cnt_n  = '0;
      code_vld_o = 1'b0;
      par_err_o  = 1'b0;
      frm_err_o  = 1'b0;
      if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYC)) begin
         frm_err_o = 1'b1;
         state_n   = IDLE;
      end else begin
         if (state != IDLE) tmo_cnt_n = tmo_cnt + 1'b1;
         if (fall) begin
            tmo_cnt_n = '0;
            unique case (state)
               IDLE: begin
                  if (!bit_in) begin
                     state_n   = DATA;
                     bit_cnt_n = '0;
                  end
               end
               DATA: begin
                  shreg_n   = {bit_in, shreg[7:1]};
                  bit_cnt_n = bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state_n = PARITY;
               end
               PARITY: begin
                  par_ok_n  = ^{bit_in, shreg};
                  par_err_o = ~par_ok_n;
                  state_n   = STOP;
               end
               STOP: begin
                  frm_err_o  = ~bit_in;
                  code_vld_o = bit_in & par_ok;
                  state_n    = IDLE;
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_sb_ctrl.sv
// PS/2 keyboard peripheral: register file, code storage and bus read mux.
// Define PS2_FIFO_EN for a FIFO_DEPTH-entry scan-code FIFO instead of one holding register.
module ps2_sb_ctrl
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 2000
`ifdef PS2_FIFO_EN
   ,
   parameter int FIFO_DEPTH = 4
`endif
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic [31:0] addr_i,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   output logic        interrupt_request_o,
   input  logic        interrupt_return_i,
   input  logic        kclk_i,
   input  logic        kdata_i
);

   logic [23:0] off;
   logic        rd, wr, soft_rst, rst_n;
   logic [7:0]  rx_code;
   logic        rx_vld, rx_par, rx_frm;
   logic        pop, stat_clr, ovr_set, unread;
   logic [7:0]  head;
   logic [2:0]  status;
   logic        unused_ok;

   assign off       = addr_i[23:0];
   assign rd        = req_i & ~write_enable_i;
   assign wr        = req_i & write_enable_i;
   assign soft_rst  = wr && off == OFS_RST && write_data_i == 32'h1;
   assign rst_n     = resetn_i & ~soft_rst;
   assign pop       = rd && off == OFS_CODE && unread;
   assign stat_clr  = rd && off == OFS_STATUS;
   assign unused_ok = ^{addr_i[31:24], interrupt_return_i};

   ps2_rx #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n),
      .kclk_i     (kclk_i),
      .kdata_i    (kdata_i),
      .code_o     (rx_code),
      .code_vld_o (rx_vld),
      .par_err_o  (rx_par),
      .frm_err_o  (rx_frm)
   );

`ifdef PS2_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic        full, push;

   assign full    = cnt == (AW + 1)'(FIFO_DEPTH);
   assign unread  = cnt != '0;
   assign head    = mem[rp];
   assign push    = rx_vld & (~full | pop);
   assign ovr_set = rx_vld & full & ~pop;

   // FIFO storage, written at the tail
   always_ff @(posedge clk_i) begin
      if (push) mem[wp] <= rx_code;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end
`else
   logic [7:0] hold;

   assign head    = hold;
   assign ovr_set = rx_vld & unread & ~pop;

   // single holding register; a new code always overwrites
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         hold   <= '0;
         unread <= 1'b0;
      end else if (rx_vld) begin
         hold   <= rx_code;
         unread <= 1'b1;
      end else if (pop) begin
         unread <= 1'b0;
      end
   end
`endif

   // sticky error bits; a new event in the clearing cycle survives
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         status <= '0;
      end else begin
         status <= (stat_clr ? 3'b000 : status)
                 | {ovr_set, rx_frm, rx_par};
      end
   end

   // registered read mux, holds when no read
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         read_data_o <= '0;
      end else if (rd) begin
         case (off)
            OFS_CODE:   read_data_o <= unread ? {24'b0, head} : 32'b0;
            OFS_UNREAD: read_data_o <= {31'b0, unread};
            OFS_STATUS: read_data_o <= {29'b0, status[ST_OVR],
                                        status[ST_FRM], status[ST_PAR]};
            default:    read_data_o <= 32'b0;
         endcase
      end
   end

   assign interrupt_request_o = unread;

endmodule

// File: tb/tb_ps2_sb_ctrl.sv
// Directed bench for ps2_sb_ctrl; follows PS2_FIFO_EN like the design.
// Drives PS/2 frames bit by bit and checks registers over the bus.
module tb_ps2_sb_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] addr;
   logic        req;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic        irq_ret;
   logic        kclk;
   logic        kdata;

   int checks = 0;
   int errors = 0;

   ps2_sb_ctrl dut (
      .clk_i               (clk),
      .resetn_i            (resetn),
      .addr_i              (addr),
      .req_i               (req),
      .write_enable_i      (we),
      .write_data_i        (wdata),
      .read_data_o         (rdata),
      .interrupt_request_o (irq),
      .interrupt_return_i  (irq_ret),
      .kclk_i              (kclk),
      .kdata_i             (kdata)
   );

   always #5 clk = ~clk;

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      req  = 1'b1;
      we   = 1'b0;
      addr = a;
      @(posedge clk);
      #1;
      req = 1'b0;
      d   = rdata;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      req   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = v;
      @(posedge clk);
      #1;
      req = 1'b0;
      we  = 1'b0;
   endtask

   task automatic ps2_bit(input logic b);
      kdata = b;
      repeat (6) @(posedge clk);
      #1 kclk = 1'b0;
      repeat (6) @(posedge clk);
      #1 kclk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic bad_par);
      logic p;
      p = ~^c ^ bad_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(c[i]);
      ps2_bit(p);
      ps2_bit(1'b1);
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      resetn  = 1'b0;
      req     = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      irq_ret = 1'b0;
      kclk    = 1'b1;
      kdata   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      bus_rd(32'h04, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL reset_unread: got %h expected %h", d, 32'h0);
      end
      bus_rd(32'h00, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL empty_code: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_good_frame();
      logic [31:0] d;
      send_frame(8'h1C, 1'b0);
      bus_rd(32'h04, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL good_unread: got %h expected %h", d, 32'h1);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL good_irq: got %b expected 1", irq);
      end
      @(negedge clk) irq_ret = 1'b1;
      @(negedge clk) irq_ret = 1'b0;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_ret_keep: got %b expected 1", irq);
      end
      bus_wr(32'h24, 32'h2);
      bus_wr(32'h00, 32'h0);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL ro_write_ign: got %b expected 1", irq);
      end
      bus_rd(32'h10, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL unmapped_rd: got %h expected %h", d, 32'h0);
      end
      bus_rd(32'h00, d);
      checks++;
      if (d !== 32'h1C) begin
         errors++;
         $display("FAIL good_code: got %h expected %h", d, 32'h1C);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h1C) begin
         errors++;
         $display("FAIL rdata_hold: got %h expected %h", rdata, 32'h1C);
      end
      bus_rd(32'h04, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL good_unread_clr: got %h expected %h", d, 32'h0);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL good_irq_clr: got %b expected 0", irq);
      end
   endtask

   task automatic test_parity();
      logic [31:0] d;
      send_frame(8'hF0, 1'b1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL par_irq: got %b expected 0", irq);
      end
      bus_rd(32'h08, d);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL par_status: got %h expected %h", d, 32'h1);
      end
      bus_rd(32'h08, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL par_status_clr: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      repeat (2010) @(posedge clk);
      bus_rd(32'h08, d);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL tmo_status: got %h expected %h", d, 32'h2);
      end
      send_frame(8'h29, 1'b0);
      bus_rd(32'h00, d);
      checks++;
      if (d !== 32'h29) begin
         errors++;
         $display("FAIL tmo_next_code: got %h expected %h", d, 32'h29);
      end
   endtask

   task automatic test_overrun();
      logic [31:0] d;
`ifdef PS2_FIFO_EN
      logic [7:0] exp_q [4];
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
      for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus_rd(32'h00, d);
         checks++;
         if (d !== {24'b0, exp_q[i]}) begin
            errors++;
            $display("FAIL fifo_code%0d: got %h expected %h", i, d, exp_q[i]);
         end
      end
      bus_rd(32'h04, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL fifo_empty: got %h expected %h", d, 32'h0);
      end
`else
      send_frame(8'h1C, 1'b0);
      send_frame(8'h32, 1'b0);
      bus_rd(32'h00, d);
      checks++;
      if (d !== 32'h32) begin
         errors++;
         $display("FAIL ovr_code: got %h expected %h", d, 32'h32);
      end
`endif
      bus_rd(32'h08, d);
      checks++;
      if (d !== 32'h4) begin
         errors++;
         $display("FAIL ovr_status: got %h expected %h", d, 32'h4);
      end
   endtask

   task automatic test_soft_reset();
      logic [31:0] d;
      send_frame(8'h1C, 1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      bus_wr(32'h24, 32'h1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL srst_irq: got %b expected 0", irq);
      end
      bus_rd(32'h04, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL srst_unread: got %h expected %h", d, 32'h0);
      end
      send_frame(8'h5A, 1'b0);
      bus_rd(32'h00, d);
      checks++;
      if (d !== 32'h5A) begin
         errors++;
         $display("FAIL srst_next: got %h expected %h", d, 32'h5A);
      end
      send_frame(8'h33, 1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      @(negedge clk) resetn = 1'b0;
      @(negedge clk) resetn = 1'b1;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL hrst_irq: got %b expected 0", irq);
      end
      bus_rd(32'h04, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL hrst_unread: got %h expected %h", d, 32'h0);
      end
      send_frame(8'h66, 1'b0);
      bus_rd(32'h00, d);
      checks++;
      if (d !== 32'h66) begin
         errors++;
         $display("FAIL hrst_next: got %h expected %h", d, 32'h66);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [7:0]  c;
      c = 8'h22;
      send_frame(8'h11, 1'b0);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(c[i]);
      ps2_bit(~^c);
      kdata = 1'b1;
      repeat (6) @(posedge clk);
      @(posedge clk);
      #1 kclk = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      req  = 1'b1;
      we   = 1'b0;
      addr = 32'h00;
      @(posedge clk);
      #1;
      req = 1'b0;
      d   = rdata;
      checks++;
      if (d !== 32'h11) begin
         errors++;
         $display("FAIL b2b_old_code: got %h expected %h", d, 32'h11);
      end
      repeat (3) @(posedge clk);
      #1 kclk = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL b2b_irq: got %b expected 1", irq);
      end
      bus_rd(32'h08, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL b2b_status: got %h expected %h", d, 32'h0);
      end
      bus_rd(32'h00, d);
      checks++;
      if (d !== 32'h22) begin
         errors++;
         $display("FAIL b2b_new_code: got %h expected %h", d, 32'h22);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL b2b_irq_clr: got %b expected 0", irq);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity();
      test_timeout();
      test_overrun();
      test_soft_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
